// File: rtl/mode_sequencer_pkg.sv
// rtl/mode_sequencer_pkg.sv - shared mode encodings, bus constants and state type
//
// Holds the video mode codes, the configuration bus address of the VGA timing
// block, the default configuration bus width and the sequencer state type.
package mode_sequencer_pkg;

    localparam int CFG_WIDTH_DEFAULT = 2;

    typedef enum logic [1:0] {
        MODE_640X480  = 2'b00,
        MODE_800X600  = 2'b01,
        MODE_1024X768 = 2'b10,
        MODE_INVALID  = 2'b11
    } mode_e;

    // Configuration bus address of the VGA timing registers.
    localparam logic [1:0] CFG_ADDR_VGA = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_FE  = 3'd1,
        ST_WRITE    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_SETTLE   = 3'd4
    } state_e;

    function automatic logic mode_is_valid(input logic [1:0] mode);
        return mode != MODE_INVALID;
    endfunction

endpackage

// File: rtl/mode_sequencer_frame_counter.sv
// rtl/mode_sequencer_frame_counter.sv - counts Frame_end pulses while a new mode settles
//
// Ports:
//   clk_i     clock
//   resetn_i  synchronous active-low reset
//   clear_i   restart the count (asserted on the cycle SETTLE is entered)
//   inc_i     one Frame_end seen while settling
//   hit_o     this increment is the TARGET-th one; constant 1 when TARGET = 0
module frame_counter #(
    parameter int TARGET = 2
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic hit_o
);

    localparam int CW = (TARGET > 1) ? $clog2(TARGET) : 1;
    localparam logic [CW-1:0] LAST = (TARGET > 1) ? CW'(TARGET - 1) : '0;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // With TARGET = 0 the settle phase needs no frames, so it completes at once.
    assign hit_o = (TARGET == 0) ? 1'b1 : (inc_i && (count_q == LAST));

    always_comb begin
        count_d = count_q;
        if (clear_i || hit_o) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mode_sequencer.sv
// rtl/mode_sequencer.sv - sequences a video mode change through blanking and a config write
//
// Ports:
//   Clk, Rst (sync, active-low)
//   Req_valid/Req_mode/Req_ready  mode change request handshake
//   Frame_end                     vertical blank start pulse from the timing generator
//   Load_config                   load acknowledge from the configuration block
//   Cfg_valid/Cfg_addr/Cfg_data   configuration bus write
//   Blank                         force RGB to black
//   Cur_mode                      currently loaded mode
//   Busy                          mode change in progress
//   Err                           sticky error (invalid request or ack timeout)
module mode_sequencer
    import mode_sequencer_pkg::*;
#(
    parameter int CONFIG_WIDTH  = CFG_WIDTH_DEFAULT,
    parameter int SETTLE_FRAMES = 2,
    parameter int ACK_TIMEOUT   = 15
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Req_valid,
    input  logic [1:0]              Req_mode,
    output logic                    Req_ready,
    input  logic                    Frame_end,
    input  logic                    Load_config,
    output logic                    Cfg_valid,
    output logic [CONFIG_WIDTH-1:0] Cfg_addr,
    output logic [CONFIG_WIDTH-1:0] Cfg_data,
    output logic                    Blank,
    output logic [1:0]              Cur_mode,
    output logic                    Busy,
    output logic                    Err
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] ACK_LAST = (ACK_TIMEOUT > 1) ? TW'(ACK_TIMEOUT - 1) : '0;

    state_e        state_q, state_d;
    logic [1:0]    cur_mode_q, cur_mode_d;
    logic [1:0]    target_q, target_d;
    logic          err_q, err_d;
    logic [TW-1:0] timer_q, timer_d;

    logic fc_clear;
    logic fc_inc;
    logic fc_hit;

    // Only pulses seen while actually settling count; pulses in WRITE/WAIT_ACK are dropped.
    assign fc_inc = (state_q == ST_SETTLE) && Frame_end;

    frame_counter #(
        .TARGET (SETTLE_FRAMES)
    ) u_frame_counter (
        .clk_i    (Clk),
        .resetn_i (Rst),
        .clear_i  (fc_clear),
        .inc_i    (fc_inc),
        .hit_o    (fc_hit)
    );

    always_comb begin
        state_d    = state_q;
        cur_mode_d = cur_mode_q;
        target_d   = target_q;
        err_d      = err_q;
        timer_d    = timer_q;
        fc_clear   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Frame_end is not looked at here, so a pulse on the accepting
                // cycle cannot advance WAIT_FE.
                if (Req_valid) begin
                    if (!mode_is_valid(Req_mode)) begin
                        err_d = 1'b1;
                    end else if (Req_mode == cur_mode_q) begin
                        err_d = 1'b0;
                    end else begin
                        target_d = Req_mode;
                        err_d    = 1'b0;
                        state_d  = ST_WAIT_FE;
                    end
                end
            end
            ST_WAIT_FE: begin
                if (Frame_end) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                timer_d = '0;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // timer_q counts completed WAIT_ACK cycles; the last allowed
                // cycle without an ack gives up and flags the error.
                if (Load_config) begin
                    cur_mode_d = target_q;
                    fc_clear   = 1'b1;
                    state_d    = ST_SETTLE;
                end else if ((ACK_TIMEOUT <= 1) || (timer_q == ACK_LAST)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (fc_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q    <= ST_IDLE;
            cur_mode_q <= MODE_640X480;
            target_q   <= MODE_640X480;
            err_q      <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            cur_mode_q <= cur_mode_d;
            target_q   <= target_d;
            err_q      <= err_d;
            timer_q    <= timer_d;
        end
    end

    // All outputs come from registers or a state decode; no input reaches an output.
    assign Req_ready = (state_q == ST_IDLE);
    assign Busy      = (state_q != ST_IDLE);
    assign Blank     = (state_q == ST_WRITE) || (state_q == ST_WAIT_ACK) || (state_q == ST_SETTLE);
    assign Cfg_valid = (state_q == ST_WRITE);
    assign Cfg_addr  = (state_q == ST_WRITE) ? CONFIG_WIDTH'(CFG_ADDR_VGA) : '0;
    assign Cfg_data  = (state_q == ST_WRITE) ? CONFIG_WIDTH'(target_q) : '0;
    assign Cur_mode  = cur_mode_q;
    assign Err       = err_q;

endmodule

// File: doc/mode_sequencer.md
MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 Parameter CONFIG_WIDTH, default 2: width of the configuration bus address and data fields.
REQ-002 Parameter SETTLE_FRAMES, default 2: number of Frame_end pulses to keep Blank high after a new mode loads.
REQ-003 Parameter ACK_TIMEOUT, default 15: maximum number of Clk cycles to wait for Load_config after a write.
REQ-004 The ports SHALL be, as name, direction, width, meaning:
- Clk, in, 1: the single clock.
- Rst, in, 1: reset, synchronous, active-low.
- Req_valid, in, 1: mode change request.
- Req_mode, in, 2: requested mode; 00 = 640x480, 01 = 800x600, 10 = 1024x768, 11 = invalid.
- Req_ready, out, 1: sequencer can accept a request.
- Frame_end, in, 1: one-cycle pulse from the timing generator at the start of vertical blank.
- Load_config, in, 1: load pulse from the configuration block.
- Cfg_valid, out, 1: configuration bus write strobe.
- Cfg_addr, out, CONFIG_WIDTH: configuration bus address.
- Cfg_data, out, CONFIG_WIDTH: configuration bus data, the mode code.
- Blank, out, 1: force RGB to black.
- Cur_mode, out, 2: currently loaded mode.
- Busy, out, 1: a mode change is in progress.
- Err, out, 1: sticky error flag.

Function
REQ-005 The block SHALL accept a request only on a cycle where Req_valid and Req_ready are both 1; Req_ready SHALL be 1 only in state IDLE.
REQ-006 The state machine SHALL have five states: IDLE, WAIT_FE, WRITE, WAIT_ACK and SETTLE.
REQ-007 On an accepted request with Req_mode equal to Cur_mode, the block SHALL stay in IDLE, perform no bus write, and clear Err.
REQ-008 On an accepted request with Req_mode = 11, the block SHALL stay in IDLE, perform no bus write, and set Err.
REQ-009 On an accepted request with a valid Req_mode different from Cur_mode, the block SHALL latch the target mode, clear Err, and enter WAIT_FE.
REQ-010 WAIT_FE SHALL move to WRITE on the first Frame_end seen while in WAIT_FE; a Frame_end on the accepting cycle SHALL NOT count.
REQ-011 Blank SHALL rise on the cycle after the qualifying Frame_end and stay high through WRITE, WAIT_ACK and SETTLE.
REQ-012 WRITE SHALL last exactly one cycle, driving Cfg_valid = 1, Cfg_addr = 2'b10 (VGA address) and Cfg_data = target mode, then enter WAIT_ACK.
REQ-013 Outside WRITE, Cfg_valid, Cfg_addr and Cfg_data SHALL be 0.
REQ-014 In WAIT_ACK, Load_config = 1 SHALL update Cur_mode to the target mode, clear the settle counter, and enter SETTLE; the expected ack arrives one cycle after WRITE.
REQ-015 Load_config in any state other than WAIT_ACK SHALL be ignored, including the pulse the configuration block emits after reset.
REQ-016 If no ack arrives within ACK_TIMEOUT cycles of entering WAIT_ACK, the block SHALL set Err, keep Cur_mode unchanged, deassert Blank, and return to IDLE.
REQ-017 SETTLE SHALL count Frame_end pulses; on the SETTLE_FRAMES-th pulse it SHALL return to IDLE, with Blank low from the next cycle. If SETTLE_FRAMES = 0, SETTLE SHALL exit after one cycle.
REQ-018 Frame_end in WRITE or WAIT_ACK SHALL be ignored.
REQ-019 Busy SHALL be 1 exactly when the state is not IDLE.
REQ-020 All outputs SHALL be registered or decoded directly from the state; there SHALL be no combinational path from any input to any output.

Reset
REQ-021 While Rst = 0 at a rising edge of Clk, the block SHALL go to state IDLE with Cur_mode = 00, Blank = 0, Cfg_valid = 0, Cfg_addr = 0, Cfg_data = 0, Err = 0, Busy = 0, Req_ready = 1 from the first cycle after release, and all counters cleared.
REQ-022 A reset during any state SHALL abort the change without issuing a bus write; Cur_mode = 00 SHALL then match the configuration block's 640x480 reset default.

Structure
REQ-023 The mode encodings, the VGA address constant (2'b10) and CONFIG_WIDTH SHALL live in the shared width/parameter include, not in this module.
REQ-024 A single sub-module, frame_counter, SHALL provide the SETTLE Frame_end counter; the timeout counter SHALL be inline.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset, then Req_valid with Req_mode = 01 -> no write before the next Frame_end; one cycle after it, a one-cycle write with Addr = 10, Data = 01; Load_config echoed -> Cur_mode = 01, Blank high for 2 frames, then Req_ready = 1.
- Request 00 while Cur_mode = 00 -> no Cfg_valid, Busy stays 0, Err = 0.
- Request 11 -> Err = 1, no write; a later valid request 10 -> Err = 0 and the change proceeds.
- Load_config held at 0 after WRITE -> Err = 1 after 15 cycles, Cur_mode unchanged, Blank = 0, back in IDLE.
- Frame_end coincident with the accepting cycle, and Frame_end pulses during WAIT_ACK -> neither advances the sequence.
- Rst = 0 asserted in SETTLE with Cur_mode = 10 -> next cycle Cur_mode = 00, Blank = 0, Busy = 0; a Load_config pulse after release is ignored.
